ccc_lock_sequencer: RTL
=======================

Name: ccc_lock_sequencer

Overview:
Sequences the fabric CCC/PLL after power-up and after lock loss. Pulses the PLL async reset, waits for and filters LOCK, and releases a fabric-side READY only after a stable lock. Bounds relock retries and reports failure. Sits in the *_sb wrapper between the FCCC instance and the fabric reset tree, clocked from the free-running RC oscillator rather than GL0.

Parameters:
RST_CYCLES, 16, PCLK cycles PLL_ARST_N is held low per attempt (min 1)
LOCK_TIMEOUT, 50000, PCLK cycles allowed in WAIT_LOCK before an attempt fails
LOCK_FILTER, 1024, consecutive PCLK cycles with synced LOCK high required before READY
MAX_RETRY, 3, failed attempts before entering FAIL (1..15)
CNT_W, 8, width of the LOSS_CNT saturating counter

Ports:
PCLK  in  1  free-running controller clock (RC oscillator)
PRESET_N  in  1  asynchronous active-low reset
LOCK  in  1  CCC LOCK, asynchronous to PCLK
RESTART  in  1  single-cycle pulse; restarts the sequence from PLL_RST, clears FAIL and RETRY_CNT
PLL_ARST_N  out  1  to CCC PLL_ARST_N
PLL_POWERDOWN_N  out  1  to CCC PLL_POWERDOWN_N
READY  out  1  registered; high only in RUN
FAIL  out  1  sticky; high in FAIL
RETRY_CNT  out  4  failed attempts in the current sequence
LOSS_CNT  out  CNT_W  lock-loss events while in RUN, saturating

Behaviour:
- Reset values: PLL_ARST_N=0, PLL_POWERDOWN_N=0, READY=0, FAIL=0, RETRY_CNT=0, LOSS_CNT=0, state=OFF. Async assert, sync deassert via a 2-flop reset synchronizer; LOCK passes through a 2-flop synchronizer (lock_s).
- OFF: 1 cycle after reset release, drive PLL_POWERDOWN_N=1 and go to PLL_RST.
- PLL_RST: PLL_ARST_N=0 for exactly RST_CYCLES cycles, then set it to 1 and go to WAIT_LOCK.
- WAIT_LOCK: lock_s=1 -> FILTER. The timer reaching LOCK_TIMEOUT -> RETRY_CNT+1. If the new value equals MAX_RETRY -> FAIL, otherwise -> PLL_RST.
- FILTER: the counter increments while lock_s=1. Any lock_s=0 returns to WAIT_LOCK with the filter count cleared and the timeout timer not reset. Count == LOCK_FILTER -> RUN.
- RUN: READY=1 from the first cycle in RUN. lock_s=0 -> READY=0 in the same registered update, LOSS_CNT+1 (saturates at all-ones), RETRY_CNT=0, go to PLL_RST.
- FAIL: PLL_ARST_N=0, PLL_POWERDOWN_N=0, READY=0, FAIL=1. Leaves FAIL only on RESTART or reset.
- RESTART in any state: go to PLL_RST next cycle, READY=0, FAIL=0, RETRY_CNT=0. LOSS_CNT is kept.
- RESTART takes priority over the same-cycle timeout, filter completion or lock loss.
- Worst-case READY latency from reset deassert: 2 (sync) + 1 + RST_CYCLES + lock time + 2 (LOCK sync) + LOCK_FILTER cycles.
- PRESET_N asserted mid-sequence returns all outputs to reset values immediately (async).

Optional Feature:
CCC_APB_RECONFIG_EN
- Defined: adds ports CFG_REQ in 1, CFG_ADDR in 6, CFG_WDATA in 8, CFG_ACK out 1, PSEL out 1, PENABLE out 1, PWRITE out 1, PADDR out 6, PWDATA out 8 (to the CCC APB port; PREADY is not used).
- CFG_REQ is sampled only in RUN or FAIL. On acceptance: READY=0, state APB_SETUP (PSEL=1, PWRITE=1, PENABLE=0, PADDR/PWDATA latched) for 1 cycle, then APB_ACCESS (PENABLE=1) for 1 cycle.
- After APB_ACCESS: CFG_ACK pulses for 1 cycle, RETRY_CNT=0, FAIL=0, go to PLL_RST.
- CFG_REQ in any other state is held pending until RUN/FAIL.
- APB outputs reset to 0.
- Undefined: none of these ports or states exist, and the FSM is as above.

Test Plan:
- Reset release, LOCK rises 100 cycles after PLL_ARST_N=1 and stays high -> PLL_ARST_N low exactly 16 cycles; READY=1 exactly 2+1024 cycles after the LOCK edge; RETRY_CNT=0.
- LOCK never rises -> three PLL_RST pulses 50000 cycles apart, then FAIL=1, RETRY_CNT=3, PLL_POWERDOWN_N=0; RESTART pulse -> FAIL=0 and a new PLL_RST.
- In RUN, LOCK glitches low for 3 cycles -> READY=0 within 3 cycles of the edge, LOSS_CNT 0->1, new 16-cycle PLL_RST, READY returns after relock plus filter.
- In FILTER, LOCK drops at count 500 -> returns to WAIT_LOCK, filter restarts from 0, READY stays 0; LOSS_CNT is unchanged.
- LOSS_CNT at 255 plus another lock loss -> stays 255; PRESET_N pulse mid-FILTER -> all outputs at reset values asynchronously.
- (CCC_APB_RECONFIG_EN) CFG_REQ with ADDR=0x0A, WDATA=0x5C in RUN -> one setup plus one access cycle with PADDR=0x0A, PWDATA=0x5C; CFG_ACK pulse; PLL_RST; READY after relock.

Source files
------------

// File: rtl/ccc_lock_sequencer.sv
// CCC/PLL power-up and relock sequencer: pulses PLL_ARST_N, filters LOCK, gates READY, bounds retries.
// Optional APB reconfiguration path enabled by defining CCC_APB_RECONFIG_EN.
module ccc_lock_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_FILTER  = 1024,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             PCLK,
  input  logic             PRESET_N,
  input  logic             LOCK,
  input  logic             RESTART,
`ifdef CCC_APB_RECONFIG_EN
  input  logic             CFG_REQ,
  input  logic [5:0]       CFG_ADDR,
  input  logic [7:0]       CFG_WDATA,
  output logic             CFG_ACK,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [5:0]       PADDR,
  output logic [7:0]       PWDATA,
`endif
  output logic             PLL_ARST_N,
  output logic             PLL_POWERDOWN_N,
  output logic             READY,
  output logic             FAIL,
  output logic [3:0]       RETRY_CNT,
  output logic [CNT_W-1:0] LOSS_CNT
);

  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam int unsigned TmoW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int unsigned FltW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER + 1) : 1;

  localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(LOCK_TIMEOUT - 1);
  localparam logic [FltW-1:0] FltLast = FltW'(LOCK_FILTER - 1);

`ifdef CCC_APB_RECONFIG_EN
  typedef enum logic [2:0] {
    StOff, StPllRst, StWaitLock, StFilter, StRun, StFail, StApbSetup, StApbAccess
  } state_e;
`else
  typedef enum logic [2:0] {
    StOff, StPllRst, StWaitLock, StFilter, StRun, StFail
  } state_e;
`endif

  // Reset: asserted asynchronously, released two PCLK edges after PRESET_N rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic lock_meta_q, lock_s;

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s      <= 1'b0;
    end else begin
      lock_meta_q <= LOCK;
      lock_s      <= lock_meta_q;
    end
  end

  state_e            state_q, state_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [FltW-1:0]   flt_q, flt_d;
  logic              arst_n_q, arst_n_d;
  logic              pdn_n_q, pdn_n_d;
  logic              ready_q, ready_d;
  logic              fail_q, fail_d;
  logic [3:0]        retry_q, retry_d;
  logic [3:0]        retry_inc;
  logic [CNT_W-1:0]  loss_q, loss_d;

`ifdef CCC_APB_RECONFIG_EN
  logic       pend_q, pend_d;
  logic [5:0] req_addr_q, req_addr_d;
  logic [7:0] req_wdata_q, req_wdata_d;
  logic       psel_q, psel_d;
  logic       penable_q, penable_d;
  logic       pwrite_q, pwrite_d;
  logic [5:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic       ack_q, ack_d;
  logic       req_any;

  assign req_any = pend_q | CFG_REQ;
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    tmo_d     = tmo_q;
    flt_d     = flt_q;
    arst_n_d  = arst_n_q;
    pdn_n_d   = pdn_n_q;
    ready_d   = ready_q;
    fail_d    = fail_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    retry_inc = retry_q + 4'd1;
`ifdef CCC_APB_RECONFIG_EN
    pend_d      = pend_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    ack_d       = 1'b0;
    // A request seen outside RUN/FAIL is parked here until it can be served.
    if (CFG_REQ && !pend_q) begin
      pend_d      = 1'b1;
      req_addr_d  = CFG_ADDR;
      req_wdata_d = CFG_WDATA;
    end
`endif

    unique case (state_q)
      StOff: begin
        state_d   = StPllRst;
        pdn_n_d   = 1'b1;
        rst_cnt_d = '0;
      end
      StPllRst: begin
        arst_n_d = 1'b0;
        if (rst_cnt_q == RstLast) begin
          state_d  = StWaitLock;
          arst_n_d = 1'b1;
          tmo_d    = '0;
          flt_d    = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (lock_s) begin
          // The detecting cycle already counts as the first filtered cycle.
          if (LOCK_FILTER <= 1) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            state_d = StFilter;
            flt_d   = FltW'(1);
          end
        end else if (tmo_q == TmoLast) begin
          retry_d = retry_inc;
          if (retry_inc == 4'(MAX_RETRY)) begin
            state_d  = StFail;
            arst_n_d = 1'b0;
            pdn_n_d  = 1'b0;
            ready_d  = 1'b0;
            fail_d   = 1'b1;
          end else begin
            state_d   = StPllRst;
            arst_n_d  = 1'b0;
            rst_cnt_d = '0;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StFilter: begin
        // Timeout timer is deliberately left untouched across filter excursions.
        if (!lock_s) begin
          state_d = StWaitLock;
          flt_d   = '0;
        end else if (flt_q == FltLast) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else begin
          flt_d = flt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d   = StPllRst;
          ready_d   = 1'b0;
          arst_n_d  = 1'b0;
          rst_cnt_d = '0;
          retry_d   = '0;
          if (loss_q != '1) begin
            loss_d = loss_q + 1'b1;
          end
        end
`ifdef CCC_APB_RECONFIG_EN
        else if (req_any) begin
          state_d   = StApbSetup;
          ready_d   = 1'b0;
          pend_d    = 1'b0;
          psel_d    = 1'b1;
          pwrite_d  = 1'b1;
          penable_d = 1'b0;
          paddr_d   = pend_q ? req_addr_q : CFG_ADDR;
          pwdata_d  = pend_q ? req_wdata_q : CFG_WDATA;
        end
`endif
      end
      StFail: begin
`ifdef CCC_APB_RECONFIG_EN
        if (req_any) begin
          state_d   = StApbSetup;
          pend_d    = 1'b0;
          psel_d    = 1'b1;
          pwrite_d  = 1'b1;
          penable_d = 1'b0;
          paddr_d   = pend_q ? req_addr_q : CFG_ADDR;
          pwdata_d  = pend_q ? req_wdata_q : CFG_WDATA;
        end
`endif
      end
`ifdef CCC_APB_RECONFIG_EN
      StApbSetup: begin
        state_d   = StApbAccess;
        penable_d = 1'b1;
      end
      StApbAccess: begin
        state_d   = StPllRst;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        ack_d     = 1'b1;
        retry_d   = '0;
        fail_d    = 1'b0;
        arst_n_d  = 1'b0;
        pdn_n_d   = 1'b1;
        rst_cnt_d = '0;
      end
`endif
      default: state_d = StOff;
    endcase

    // RESTART overrides every same-cycle transition; LOSS_CNT is kept.
    if (RESTART) begin
      state_d   = StPllRst;
      rst_cnt_d = '0;
      flt_d     = '0;
      arst_n_d  = 1'b0;
      pdn_n_d   = 1'b1;
      ready_d   = 1'b0;
      fail_d    = 1'b0;
      retry_d   = '0;
      loss_d    = loss_q;
`ifdef CCC_APB_RECONFIG_EN
      pend_d    = pend_q | CFG_REQ;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      ack_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StOff;
      rst_cnt_q <= '0;
      tmo_q     <= '0;
      flt_q     <= '0;
      arst_n_q  <= 1'b0;
      pdn_n_q   <= 1'b0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      retry_q   <= '0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      tmo_q     <= tmo_d;
      flt_q     <= flt_d;
      arst_n_q  <= arst_n_d;
      pdn_n_q   <= pdn_n_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
    end
  end

`ifdef CCC_APB_RECONFIG_EN
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      ack_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      ack_q       <= ack_d;
    end
  end

  assign CFG_ACK = ack_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
`endif

  assign PLL_ARST_N      = arst_n_q;
  assign PLL_POWERDOWN_N = pdn_n_q;
  assign READY           = ready_q;
  assign FAIL            = fail_q;
  assign RETRY_CNT       = retry_q;
  assign LOSS_CNT        = loss_q;

endmodule
